// File: rtl/dv_flush_scanner_if.sv
// ----------------------------------------------------------------------------
// dv_flush_scanner_if
// Signal bundle between the cache flush scanner and its surroundings: the
// flush request/status handshake, the valid/dirty array read and clear port,
// and the writeback request handshake.
//
// Modports:
//   master : the flush scanner itself (drives index, clears and wb requests)
//   slave  : the cache/controller side (drives flush_req, array bits, wb_ack)
//
// Optional: FLUSH_WB_COUNT_EN adds the 8-bit wb_count status signal.
// ----------------------------------------------------------------------------
interface dv_flush_scanner_if #(
    parameter int INDEX_W = 3
);
    logic               flush_req;
    logic               flush_busy;
    logic               flush_done;
    logic [INDEX_W-1:0] index;
    logic [7:0]         valid_bits;
    logic [7:0]         dirty_bits;
    logic               clear_write;
    logic [2:0]         clear_sel;
    logic [7:0]         clear_data;
    logic               wb_req;
    logic [2:0]         wb_way;
    logic [INDEX_W-1:0] wb_index;
    logic               wb_ack;
`ifdef FLUSH_WB_COUNT_EN
    logic [7:0]         wb_count;
`endif

    modport master (
        input  flush_req, valid_bits, dirty_bits, wb_ack,
        output flush_busy, flush_done, index, clear_write, clear_sel,
`ifdef FLUSH_WB_COUNT_EN
        output wb_count,
`endif
        output clear_data, wb_req, wb_way, wb_index
    );

    modport slave (
        output flush_req, valid_bits, dirty_bits, wb_ack,
        input  flush_busy, flush_done, index, clear_write, clear_sel,
`ifdef FLUSH_WB_COUNT_EN
        input  wb_count,
`endif
        input  clear_data, wb_req, wb_way, wb_index
    );
endinterface

// File: rtl/dv_flush_scanner.sv
// ----------------------------------------------------------------------------
// dv_flush_scanner
// Walks every set of the cache and, for each way that is both valid and
// dirty, raises a writeback request and then clears that dirty bit. A set is
// re-read after every clear so remaining dirty ways are picked up lowest
// first. Dirty-but-invalid ways are ignored.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : dv_flush_scanner_if.master (flush handshake, array index and
//            dirty clear, writeback request/ack)
//
// Optional: define FLUSH_WB_COUNT_EN to add bus.wb_count, a saturating count
// of lines written back during the most recent flush.
//
// state | meaning
// IDLE  | waiting for flush_req
// READ  | index presented, array outputs settling
// SCAN  | pick lowest valid&dirty way, or advance to next set / finish
// REQ   | wb_req held until wb_ack
// CLEAR | one-cycle dirty-bit clear of wb_way, then re-read same set
// DONE  | flush_done pulse, index back to 0
// ----------------------------------------------------------------------------
module dv_flush_scanner #(
    parameter int INDEX_W = 3,
    parameter int WAYS    = 8
) (
    input  logic                clk,
    input  logic                reset,
    dv_flush_scanner_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        SCAN  = 3'd2,
        REQ   = 3'd3,
        CLEAR = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [INDEX_W-1:0] LAST_INDEX = '1;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [2:0]         wb_way_q, wb_way_d;
    logic [7:0]         hit;
    logic [2:0]         lowest_way;

    assign hit = bus.valid_bits & bus.dirty_bits;

    // Scan from the top down so the last assignment wins with the lowest way.
    always_comb begin
        lowest_way = 3'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit[w]) begin
                lowest_way = 3'(w);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            index_q  <= '0;
            wb_way_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            wb_way_q <= wb_way_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        wb_way_d = wb_way_q;
        case (state_q)
            IDLE: begin
                if (bus.flush_req) begin
                    index_d = '0;
                    state_d = READ;
                end
            end
            READ: state_d = SCAN;
            SCAN: begin
                if (hit != 8'h00) begin
                    wb_way_d = lowest_way;
                    state_d  = REQ;
                end else if (index_q == LAST_INDEX) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = READ;
                end
            end
            REQ: begin
                if (bus.wb_ack) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = READ;
            DONE: begin
                index_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from the state register so an async reset
    // drops them in the same cycle.
    assign bus.flush_busy  = (state_q != IDLE);
    assign bus.flush_done  = (state_q == DONE);
    assign bus.index       = index_q;
    assign bus.clear_write = (state_q == CLEAR);
    assign bus.clear_sel   = wb_way_q;
    assign bus.clear_data  = 8'h00;
    assign bus.wb_req      = (state_q == REQ);
    assign bus.wb_way      = wb_way_q;
    assign bus.wb_index    = index_q;

`ifdef FLUSH_WB_COUNT_EN
    logic [7:0] wb_count_q, wb_count_d;

    always_comb begin
        wb_count_d = wb_count_q;
        if (state_q == IDLE && bus.flush_req) begin
            wb_count_d = 8'h00;
        end else if (state_q == CLEAR && wb_count_q != 8'hFF) begin
            wb_count_d = wb_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_count_q <= 8'h00;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign bus.wb_count = wb_count_q;
`endif

endmodule

// File: doc/dv_flush_scanner.md
DV_FLUSH_SCANNER -- requirements
Module: dv_flush_scanner

Interface
REQ-001 Parameter: INDEX_W, 3, width of lc3b_c_index; set count = 2**INDEX_W.
REQ-002 Parameter: WAYS, 8, number of ways; way select is 3 bits.
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: flush_req  in  1  start flush; sampled in IDLE only.
REQ-006 Port: flush_busy  out  1  high in every state except IDLE.
REQ-007 Port: flush_done  out  1  one-cycle pulse at flush completion.
REQ-008 Port: index  out  INDEX_W  set index driven to valid/dirty arrays.
REQ-009 Port: valid_bits  in  8  way0..way7 valid bits at index (bit n = way n).
REQ-010 Port: dirty_bits  in  8  way0..way7 dirty bits at index.
REQ-011 Port: clear_write  out  1  dirty-array write strobe.
REQ-012 Port: clear_sel  out  3  way select for clear_write.
REQ-013 Port: clear_data  out  8  dirty-array datain; constant 8'h00.
REQ-014 Port: wb_req  out  1  writeback request, level, held until wb_ack.
REQ-015 Port: wb_way  out  3  way to write back; stable while wb_req.
REQ-016 Port: wb_index  out  INDEX_W  set to write back; equals index while wb_req.
REQ-017 Port: wb_ack  in  1  writeback complete; meaningful only while wb_req=1.

Function
REQ-018 FSM states SHALL be IDLE, READ, SCAN, REQ, CLEAR, DONE.
REQ-019 IDLE: flush_req=1 -> index<=0, go READ; else stay; flush_req outside IDLE ignored.
REQ-020 READ: one settle cycle with index stable; go SCAN.
REQ-021 SCAN: hit = valid_bits & dirty_bits; hit!=0 -> wb_way<=lowest set bit, go REQ.
REQ-022 SCAN: hit==0 and index==2**INDEX_W-1 -> go DONE; else index<=index+1 (no wrap during flush), go READ.
REQ-023 REQ: wb_req=1; wb_ack=1 in any REQ cycle (including first) -> go CLEAR next edge; else stay.
REQ-024 CLEAR: clear_write=1, clear_sel=wb_way for exactly one cycle; go READ (same index, re-scan).
REQ-025 DONE: flush_done=1 for one cycle; index<=0; go IDLE.
REQ-026 clear_write SHALL be 0 outside CLEAR; wb_req SHALL be 0 outside REQ.
REQ-027 Dirty-but-invalid ways SHALL be skipped and never cleared.
REQ-028 Minimum flush latency, all sets clean: 2*2**INDEX_W+1 cycles from flush_req to flush_done.
REQ-029 Per dirty line cost: REQ cycles (>=1) + CLEAR + READ + SCAN.

Reset
REQ-030 reset SHALL asynchronously force IDLE, index=0, wb_way=0; all outputs low (clear_data 8'h00).
REQ-031 reset mid-REQ SHALL drop wb_req immediately; no CLEAR or flush_done follows.
REQ-032 First flush_req sampled on first rising edge after reset deasserts.

Configuration
REQ-033 FLUSH_WB_COUNT_EN defined: add output wb_count (8 bits), cleared on reset and on IDLE->READ, +1 per CLEAR cycle, saturating at 8'hFF, held after DONE.
REQ-034 FLUSH_WB_COUNT_EN undefined: wb_count port and counter absent; all other behaviour identical.

Verification
REQ-035 All sets clean, flush_req pulse -> no wb_req, flush_done exactly 17 cycles after flush_req (INDEX_W=3).
REQ-036 Set 5 valid=8'h0C, dirty=8'h0E -> wb_req way 2 idx 5, then way 3 idx 5; way 1 never requested; two clear_write pulses.
REQ-037 wb_ack held low 10 cycles -> wb_req, wb_way, wb_index stable all 10 cycles; wb_ack same cycle as wb_req rise -> CLEAR next cycle.
REQ-038 reset asserted while wb_req=1 -> wb_req, flush_busy low same cycle; no flush_done; next flush starts at index 0.
REQ-039 flush_req held high throughout flush -> flush ignored while busy; new flush begins the cycle after DONE.
REQ-040 FLUSH_WB_COUNT_EN defined, 3 dirty-valid lines across sets 0,7 -> wb_count=3 after flush_done; restart clears it to 0.
